// File: rtl/acq_ctrl_pkg.sv
// Shared definitions for the acquisition controller: default parameters,
// the FSM state encoding and a counter-width helper.
// Optional watchdog feature is enabled by defining ACQ_TIMEOUT_EN.
package acq_ctrl_pkg;

  // Default configuration
  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_CONV_TARGET    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // FSM state set; ST_ERROR is only reachable when the watchdog is built in
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE          = 3'd0;
  localparam logic [STATE_W-1:0] ST_ACQUIRE       = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_COMPLETE = 3'd2;
  localparam logic [STATE_W-1:0] ST_COMPARE       = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERROR         = 3'd4;

  // Bits needed to hold 0..target inclusive, so a saturating count never wraps
  function automatic int cnt_width(input int target);
    return (target < 1) ? 1 : $clog2(target + 1);
  endfunction

endpackage

// File: rtl/acq_ch_counter.sv
// Per-channel end-of-conversion edge detector with saturating counter.
// Latency: done_o rises the cycle after the edge that reaches the target.
// No backpressure: edges are dropped when counting is disabled or saturated.
module acq_ch_counter
  import acq_ctrl_pkg::*;
#(
  parameter int CONV_TARGET = DEF_CONV_TARGET
) (
  input  logic clk,
  input  logic rst,
  input  logic eoc_i,
  input  logic count_en_i,
  input  logic clr_i,
  output logic done_o
);

  localparam int                CNT_W  = cnt_width(CONV_TARGET);
  localparam logic [CNT_W-1:0]  TARGET = CNT_W'(CONV_TARGET);

  logic             eoc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rise;

  // The edge register runs in every state so an eoc level that was already
  // high when counting opens is never mistaken for a fresh conversion.
  assign rise = eoc_i & ~eoc_q;

  // Next count: a clear beats a coincident edge; saturate at the target
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (count_en_i && rise && (cnt_q != TARGET)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Edge history and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      eoc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      eoc_q <= eoc_i;
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == TARGET);

endmodule

// File: rtl/acq_control_unit.sv
// Acquisition round sequencer: counts conversions per channel, waits for
// downstream completion, launches the comparator. Outputs are 0-1 cycle late.
// Rounds stall indefinitely on missing inputs unless ACQ_TIMEOUT_EN builds in the watchdog.
module acq_control_unit
  import acq_ctrl_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int CONV_TARGET    = DEF_CONV_TARGET,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] eoc,
  input  logic [NUM_CH-1:0] complete,
  input  logic              complete_comparator,
  output logic [NUM_CH-1:0] done,
  output logic              start_comparator,
  output logic              busy,
  output logic              error
);

  if (NUM_CH < 1 || CONV_TARGET < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("acq_control_unit: NUM_CH, CONV_TARGET and TIMEOUT_CYCLES must all be >= 1");
  end

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               start_q;
  logic               start_d;
  logic               clr_cnt;
  logic               count_en;
  logic               all_done;
  logic               all_complete;

  assign all_done     = &done;
  assign all_complete = &complete;
  assign count_en     = (state_q == ST_ACQUIRE);

`ifdef ACQ_TIMEOUT_EN
  localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;
  logic            wd_active;

  assign wd_active = (state_q == ST_ACQUIRE) || (state_q == ST_WAIT_COMPLETE) ||
                     (state_q == ST_COMPARE);
`endif

  // Next-state logic; counters clear on round start, round end and watchdog trip
  always_comb begin
    state_d = state_q;
    clr_cnt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ACQUIRE;
          clr_cnt = 1'b1;
        end
      end
      ST_ACQUIRE: begin
        if (all_done) state_d = ST_WAIT_COMPLETE;
      end
      ST_WAIT_COMPLETE: begin
        if (all_complete) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (complete_comparator) begin
          state_d = ST_IDLE;
          clr_cnt = 1'b1;
        end
      end
`ifdef ACQ_TIMEOUT_EN
      ST_ERROR: begin
        // Stay latched until the host withdraws enable
        if (!enable) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef ACQ_TIMEOUT_EN
    // Normal progress in the same cycle takes precedence over expiry
    if (wd_active && (state_d == state_q) && (wd_q == WD_LAST)) begin
      state_d = ST_ERROR;
      clr_cnt = 1'b1;
    end
`endif
  end

`ifdef ACQ_TIMEOUT_EN
  // Watchdog counts cycles spent in one active state, restarting on any change
  always_comb begin
    wd_d = '0;
    if (wd_active && (state_d == state_q)) wd_d = wd_q + WD_W'(1);
  end
`endif

  // The comparator launch is registered so it lines up with entering COMPARE
  always_comb begin
    start_d = (state_q == ST_WAIT_COMPLETE) && (state_d == ST_COMPARE);
  end

  // Controller state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
`ifdef ACQ_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
`ifdef ACQ_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    acq_ch_counter #(
      .CONV_TARGET(CONV_TARGET)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .eoc_i      (eoc[g]),
      .count_en_i (count_en),
      .clr_i      (clr_cnt),
      .done_o     (done[g])
    );
  end

  assign start_comparator = start_q;
  assign busy             = (state_q != ST_IDLE);
`ifdef ACQ_TIMEOUT_EN
  assign error            = (state_q == ST_ERROR);
`else
  assign error            = 1'b0;
`endif

endmodule
